prbs9_checker: RTL and testbench
================================

Name: prbs9_checker

Overview:
Receive-side counterpart of the PRBS9 generator (polynomial x^9 + x^5 + 1, MSB-first output).
- Self-synchronises to an incoming PRBS9 bit stream and declares lock.
- Once locked, free-runs a local replica and counts bit errors and compared bits for BER measurement.
- Sits at the sink end of loopback and channel test paths, after the slicer/decision stage.

Parameters:
LOCK_CNT, 32, consecutive matching predictions required in SEARCH to declare lock (1..255)
WIN_LEN, 128, length in compared bits of the loss-of-lock observation window (2..65535)
LOSS_THR, 8, errors within one window that force loss of lock (1..WIN_LEN)
CNT_W, 32, width of err_cnt and bit_cnt

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
in_valid  in  1  bit_in is sampled on this rising edge of clk
bit_in  in  1  received PRBS9 bit
clr  in  1  synchronous clear of err_cnt and bit_cnt (does not affect lock state)
locked  out  1  1 = checker in LOCKED state
err_pulse  out  1  one-cycle pulse: the bit sampled on the previous edge mismatched (LOCKED only)
err_cnt  out  CNT_W  saturating count of mismatched bits while LOCKED
bit_cnt  out  CNT_W  saturating count of compared bits while LOCKED

Behaviour:
- Reset values (asynchronous on rst_n=0):
  - locked=0, err_pulse=0, err_cnt=0, bit_cnt=0
  - state=SEARCH; hist=0, fill=0, match_cnt=0, win_cnt=0, win_err=0
  - Reset asserted mid-operation returns all of the above immediately.
- hist[8:0] shifts left, inserting at hist[0].
  - pred = hist[8] ^ hist[4], i.e. b[n] = b[n-9] ^ b[n-5].
  - err_now = bit_in ^ pred.
- Only edges with in_valid=1 advance anything. When in_valid=0, all state holds and err_pulse=0.
- SEARCH state (hist inserts bit_in, self-synchronising):
  - While fill<9: fill++ with no comparison.
  - When fill==9, each valid bit is compared:
    - A match with hist!=0 increments match_cnt.
    - A mismatch, or hist==0, clears match_cnt to 0. This zero-state guard means an all-zero input never locks.
  - When a match makes match_cnt reach LOCK_CNT: on that edge go to LOCKED, locked=1, win_cnt=0, win_err=0.
  - That bit is not added to bit_cnt.
- LOCKED state (hist inserts pred, free-running):
  - A single line error is counted exactly once; there is no error multiplication.
  - Each valid bit: bit_cnt++ (saturating at 2^CNT_W-1).
  - If err_now: err_cnt++ (saturating) and err_pulse=1 on the next cycle for exactly one cycle.
  - Window counting: win_cnt++ and win_err += err_now.
  - If win_err+err_now >= LOSS_THR: go to SEARCH on this edge.
    - locked=0; fill, match_cnt and hist cleared.
    - err_cnt and bit_cnt hold.
  - Otherwise, if win_cnt == WIN_LEN-1: win_cnt=0 and win_err=0 after evaluation.
- Latency: err_pulse and the counters reflect a sampled bit one clock after its valid edge. locked changes on the deciding edge.
- clr=1:
  - err_cnt=0 and bit_cnt=0 next edge.
  - If a valid compare occurs on the same edge, clr wins and that bit is not counted. err_pulse is still generated.
- Saturated counters stay at max until clr or reset.

Decomposition:
- Shared package prbs_pkg:
  - PRBS9 constants: order 9, tap indices 8 and 4, default seed 9'h1AA.
  - State enum {SEARCH, LOCKED}.
  - These are shared with the generator so both ends use identical taps.
- One sub-module is natural: prbs_sat_cnt (width-parameterised saturating counter with inc/clr), instantiated for err_cnt and bit_cnt.
- Window and lock logic stay inline.

Test Plan:
- Generator (SEED 9'h1AA, en=1) drives bit_in with in_valid=1 -> locked rises on the edge sampling valid bit 41 (9 fill + 32 matches); after 1000 further bits, bit_cnt=1000 and err_cnt=0.
- After lock, flip one bit -> err_pulse high for exactly 1 cycle, err_cnt=1, locked stays 1; 500 clean bits later err_cnt is still 1.
- bit_in held at 0, or at 1, with in_valid=1 for 2000 cycles -> locked never asserts, err_cnt=0, bit_cnt=0.
- After lock, corrupt 8 bits within 100 bits -> locked falls on the 8th error's edge; err_cnt=8; clean stream relocks 41 valid bits later.
- in_valid toggled 1-0-0-1 pseudo-randomly with a clean stream -> lock after exactly 41 valid bits; bit_cnt equals the valid-bit count.
- clr pulsed on the same edge as an error bit -> err_cnt=0, bit_cnt=0, err_pulse=1. Then rst_n pulsed low mid-stream -> all outputs 0 immediately, relock after 41 valid bits.

Source files
------------

// File: rtl/prbs_pkg.sv
`default_nettype none
// prbs_pkg: PRBS9 (x^9 + x^5 + 1) constants and state encoding shared by generator and checker.
package prbs_pkg;

  localparam int PRBS9_ORDER  = 9;
  localparam int PRBS9_TAP_HI = 8;
  localparam int PRBS9_TAP_LO = 4;
  localparam logic [PRBS9_ORDER-1:0] PRBS9_SEED = 9'h1AA;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } prbs_state_e;

  // Next bit of the sequence given the last nine, oldest in the MSB.
  function automatic logic prbs9_fb(input logic [PRBS9_ORDER-1:0] hist);
    return hist[PRBS9_TAP_HI] ^ hist[PRBS9_TAP_LO];
  endfunction

endpackage
`default_nettype wire

// File: rtl/prbs_sat_cnt.sv
`default_nettype none
// prbs_sat_cnt: width-parameterised up-counter that sticks at all-ones; clr has priority over inc.
module prbs_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/prbs9_checker.sv
`default_nettype none
// prbs9_checker: self-synchronising PRBS9 receiver with lock detection, windowed loss-of-lock
// and saturating error/bit counters for BER measurement.
module prbs9_checker
  import prbs_pkg::*;
#(
  parameter int LOCK_CNT = 32,
  parameter int WIN_LEN  = 128,
  parameter int LOSS_THR = 8,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             bit_in,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam logic [3:0]  FILL_FULL = 4'(PRBS9_ORDER);
  localparam logic [8:0]  LOCK_TGT  = 9'(LOCK_CNT);
  localparam logic [15:0] WIN_LAST  = 16'(WIN_LEN - 1);
  localparam logic [16:0] LOSS_LIM  = 17'(LOSS_THR);

  prbs_state_e            state;
  logic [PRBS9_ORDER-1:0] hist;
  logic [3:0]             fill;
  logic [7:0]             match_cnt;
  logic [15:0]            win_cnt;
  logic [15:0]            win_err;

  logic        pred;
  logic        err_now;
  logic        compare;
  logic [8:0]  match_nxt;
  logic [16:0] win_err_nxt;

  assign pred        = prbs9_fb(hist);
  assign err_now     = bit_in ^ pred;
  assign compare     = in_valid && (state == LOCKED);
  assign match_nxt   = {1'b0, match_cnt} + 9'd1;
  assign win_err_nxt = {1'b0, win_err} + {16'd0, err_now};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEARCH;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      hist      <= '0;
      fill      <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (in_valid) begin
        case (state)
          SEARCH: begin
            hist <= {hist[PRBS9_ORDER-2:0], bit_in};
            if (fill != FILL_FULL) begin
              fill <= fill + 4'd1;
            end else if (!err_now && (hist != '0)) begin
              // An all-zero history predicts zeros forever, so it never counts as a match.
              if (match_nxt == LOCK_TGT) begin
                state     <= LOCKED;
                locked    <= 1'b1;
                match_cnt <= '0;
                win_cnt   <= '0;
                win_err   <= '0;
              end else begin
                match_cnt <= match_nxt[7:0];
              end
            end else begin
              match_cnt <= '0;
            end
          end
          LOCKED: begin
            err_pulse <= err_now;
            if (win_err_nxt >= LOSS_LIM) begin
              state     <= SEARCH;
              locked    <= 1'b0;
              hist      <= '0;
              fill      <= '0;
              match_cnt <= '0;
            end else begin
              // Free-running replica: line errors never enter the history.
              hist <= {hist[PRBS9_ORDER-2:0], pred};
              if (win_cnt == WIN_LAST) begin
                win_cnt <= '0;
                win_err <= '0;
              end else begin
                win_cnt <= win_cnt + 16'd1;
                win_err <= win_err_nxt[15:0];
              end
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

  prbs_sat_cnt #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (compare && err_now),
    .cnt   (err_cnt)
  );

  prbs_sat_cnt #(.W(CNT_W)) u_bit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (compare),
    .cnt   (bit_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_prbs9_checker.sv
`default_nettype none
// tb_prbs9_checker: directed bench driving a reference PRBS9 stream into prbs9_checker.
module tb_prbs9_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        bit_in = 1'b0;
  logic        clr = 1'b0;
  logic        locked;
  logic        err_pulse;
  logic [31:0] err_cnt;
  logic [31:0] bit_cnt;

  int tests = 0;
  int fails = 0;

  logic [8:0] g;
  int         sent;
  int         lock_at;
  logic       ever_locked;
  logic [3:0] pat;
  int         vcnt;
  int         vcnt_after;

  prbs9_checker #(
    .LOCK_CNT (32),
    .WIN_LEN  (128),
    .LOSS_THR (8),
    .CNT_W    (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .bit_in    (bit_in),
    .clr       (clr),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt),
    .bit_cnt   (bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic b, input logic v, input logic c);
    @(negedge clk);
    bit_in   = b;
    in_valid = v;
    clr      = c;
    @(posedge clk);
    #1;
  endtask

  // Reference generator: output MSB, shift left inserting g[8]^g[4].
  task automatic gen_step(input logic flip, input logic c);
    logic b;
    b = g[8] ^ flip;
    g = {g[7:0], g[8] ^ g[4]};
    sent++;
    step(b, 1'b1, c);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; bit_in = 1'b0; clr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    g = 9'h1AA;
  endtask

  initial begin
    g = 9'h1AA;
    sent = 0;
    lock_at = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_locked", {63'd0, locked}, 64'd0);
    check("rst_err_pulse", {63'd0, err_pulse}, 64'd0);
    check("rst_err_cnt", {32'd0, err_cnt}, 64'd0);
    check("rst_bit_cnt", {32'd0, bit_cnt}, 64'd0);
    rst_n = 1'b1;

    // Clean acquisition: 9 fill + 32 matches
    repeat (40) gen_step(1'b0, 1'b0);
    check("acq_not_yet", {63'd0, locked}, 64'd0);
    gen_step(1'b0, 1'b0);
    lock_at = sent;
    check("acq_locked", {63'd0, locked}, 64'd1);
    check("acq_bitcnt0", {32'd0, bit_cnt}, 64'd0);
    repeat (1000) gen_step(1'b0, 1'b0);
    check("clean_bit_cnt", {32'd0, bit_cnt}, 64'd1000);
    check("clean_err_cnt", {32'd0, err_cnt}, 64'd0);

    // Single error
    gen_step(1'b1, 1'b0);
    check("single_pulse", {63'd0, err_pulse}, 64'd1);
    check("single_err_cnt", {32'd0, err_cnt}, 64'd1);
    check("single_locked", {63'd0, locked}, 64'd1);
    gen_step(1'b0, 1'b0);
    check("single_pulse_low", {63'd0, err_pulse}, 64'd0);
    repeat (499) gen_step(1'b0, 1'b0);
    check("single_err_hold", {32'd0, err_cnt}, 64'd1);
    check("single_bit_cnt", {32'd0, bit_cnt}, 64'd1501);

    // Align to a window boundary, clear counters, then 8 errors in 71 bits
    while (((sent - lock_at) % 128) != 0) gen_step(1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    check("clr_idle_err", {32'd0, err_cnt}, 64'd0);
    check("clr_idle_bit", {32'd0, bit_cnt}, 64'd0);
    for (int i = 0; i <= 70; i++) begin
      gen_step((i % 10) == 0, 1'b0);
      if (i == 60) check("burst_7_locked", {63'd0, locked}, 64'd1);
    end
    check("burst_8_lost", {63'd0, locked}, 64'd0);
    check("burst_err_cnt", {32'd0, err_cnt}, 64'd8);
    check("burst_bit_cnt", {32'd0, bit_cnt}, 64'd71);
    repeat (40) gen_step(1'b0, 1'b0);
    check("relock_not_yet", {63'd0, locked}, 64'd0);
    gen_step(1'b0, 1'b0);
    check("relock", {63'd0, locked}, 64'd1);
    check("relock_err_hold", {32'd0, err_cnt}, 64'd8);

    // Constant zero and constant one never lock
    do_reset();
    ever_locked = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      step(1'b0, 1'b1, 1'b0);
      ever_locked |= locked;
    end
    check("zeros_never_lock", {63'd0, ever_locked}, 64'd0);
    check("zeros_err_cnt", {32'd0, err_cnt}, 64'd0);
    check("zeros_bit_cnt", {32'd0, bit_cnt}, 64'd0);
    do_reset();
    ever_locked = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      step(1'b1, 1'b1, 1'b0);
      ever_locked |= locked;
    end
    check("ones_never_lock", {63'd0, ever_locked}, 64'd0);
    check("ones_err_cnt", {32'd0, err_cnt}, 64'd0);
    check("ones_bit_cnt", {32'd0, bit_cnt}, 64'd0);

    // Gapped valid pattern 1-0-0-1
    do_reset();
    pat = 4'b1001;
    vcnt = 0;
    for (int k = 0; vcnt < 41; k++) begin
      if (pat[k % 4]) begin
        gen_step(1'b0, 1'b0);
        vcnt++;
        if (vcnt == 40) check("gap_not_yet", {63'd0, locked}, 64'd0);
      end else begin
        step(1'b0, 1'b0, 1'b0);
        check("gap_idle_pulse", {63'd0, err_pulse}, 64'd0);
      end
    end
    check("gap_locked", {63'd0, locked}, 64'd1);
    vcnt_after = 0;
    for (int k = 0; k < 300; k++) begin
      if (pat[k % 4]) begin
        gen_step(1'b0, 1'b0);
        vcnt_after++;
      end else begin
        step(1'b1, 1'b0, 1'b0);
      end
    end
    check("gap_bit_cnt", {32'd0, bit_cnt}, 64'(vcnt_after));
    check("gap_err_cnt", {32'd0, err_cnt}, 64'd0);

    // clr on an error edge, then asynchronous reset mid-stream
    gen_step(1'b1, 1'b1);
    check("clr_err_cnt", {32'd0, err_cnt}, 64'd0);
    check("clr_bit_cnt", {32'd0, bit_cnt}, 64'd0);
    check("clr_pulse", {63'd0, err_pulse}, 64'd1);
    repeat (20) gen_step(1'b0, 1'b0);
    gen_step(1'b1, 1'b0);
    check("pre_rst_err_cnt", {32'd0, err_cnt}, 64'd1);
    check("pre_rst_bit_cnt", {32'd0, bit_cnt}, 64'd21);
    rst_n = 1'b0;
    #2;
    check("arst_locked", {63'd0, locked}, 64'd0);
    check("arst_pulse", {63'd0, err_pulse}, 64'd0);
    check("arst_err_cnt", {32'd0, err_cnt}, 64'd0);
    check("arst_bit_cnt", {32'd0, bit_cnt}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) gen_step(1'b0, 1'b0);
    check("arst_relock_not_yet", {63'd0, locked}, 64'd0);
    gen_step(1'b0, 1'b0);
    check("arst_relock", {63'd0, locked}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
